// File: rtl/uat_top.sv
// rtl/uat_top.sv - 16x-oversampled UART transmitter, LSB first, 1 or 2 stop bits
//
// Purpose: serialises one byte per frame on ser_out:
//   start bit (0), data bits 0..7, optional even parity bit, then STOP_BITS stop bits (1).
//   Each bit lasts 16 clk_16x cycles.
// Optional feature: define UAT_PARITY_EN to insert an even-parity bit between data and stop.
// Parameters:
//   STOP_BITS  stop bits per frame, 1 or 2
// Ports:
//   clk_16x   in   clock at 16x the bit rate
//   rst_n     in   asynchronous active-low reset
//   din_rdy   in   load strobe, accepted only while idle
//   din_byte  in   byte to send, latched on the accepting edge
//   ser_out   out  registered serial line, idle high
//   tx_busy   out  high while a frame is in progress
//   tx_done   out  one-cycle pulse in the first idle cycle after a frame
module uat_top #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk_16x,
  input  logic       rst_n,
  input  logic       din_rdy,
  input  logic [7:0] din_byte,
  output logic       ser_out,
  output logic       tx_busy,
  output logic       tx_done
);

`ifdef UAT_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  // Index of the final stop bit, compared against the bit counter in STOP.
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  state_e      state_q, state_d;
  logic [3:0]  sample_q, sample_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        ser_out_q, ser_out_d;
  logic        tx_done_q, tx_done_d;
  logic        sample_wrap;
`ifdef UAT_PARITY_EN
  // Parity is captured at accept time because the shift register is consumed during DATA.
  logic        parity_q, parity_d;
`endif

  assign sample_wrap = (sample_q == 4'd15);

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_done_d = 1'b0;
    ser_out_d = 1'b1;
`ifdef UAT_PARITY_EN
    parity_d  = parity_q;
`endif

    // The sample counter free-runs while a frame is active; its natural 15->0
    // wrap marks every bit boundary.
    if (state_q != S_IDLE) begin
      sample_d = sample_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (din_rdy) begin
          state_d  = S_START;
          shift_d  = din_byte;
          sample_d = 4'd0;
          bit_d    = 3'd0;
`ifdef UAT_PARITY_EN
          parity_d = ^din_byte;
`endif
        end
      end
      S_START: begin
        if (sample_wrap) state_d = S_DATA;
      end
      S_DATA: begin
        if (sample_wrap) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          // bit_q wraps 7->0 here, so STOP starts with the bit counter at 0.
          if (bit_q == 3'd7) begin
`ifdef UAT_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UAT_PARITY_EN
      S_PARITY: begin
        if (sample_wrap) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (sample_wrap) begin
          if (bit_q == STOP_LAST) begin
            state_d   = S_IDLE;
            bit_d     = 3'd0;
            tx_done_d = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ser_out is registered, so it is derived from the state being entered.
    case (state_d)
      S_START:  ser_out_d = 1'b0;
      S_DATA:   ser_out_d = shift_d[0];
`ifdef UAT_PARITY_EN
      S_PARITY: ser_out_d = parity_d;
`endif
      default:  ser_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_16x or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sample_q  <= 4'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      ser_out_q <= 1'b1;
      tx_done_q <= 1'b0;
`ifdef UAT_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ser_out_q <= ser_out_d;
      tx_done_q <= tx_done_d;
`ifdef UAT_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign ser_out = ser_out_q;
  assign tx_busy = (state_q != S_IDLE);
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uat_top.sv
// tb/tb_uat_top.sv - directed self-checking bench for uat_top (1 and 2 stop bits)
module tb_uat_top;

`ifdef UAT_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL1 = 16 * (10 + P);
  localparam int FL2 = 16 * (11 + P);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_rdy = 1'b0;
  logic [7:0] din_byte = 8'h00;
  logic       ser1, busy1, done1;
  logic       ser2, busy2, done2;

  int checks = 0;
  int failures = 0;

  logic ln [0:511];
  logic bz [0:511];
  logic dn [0:511];

  always #5 clk = ~clk;

  uat_top #(.STOP_BITS(1)) u_dut1 (
    .clk_16x(clk), .rst_n(rst_n), .din_rdy(din_rdy), .din_byte(din_byte),
    .ser_out(ser1), .tx_busy(busy1), .tx_done(done1)
  );

  uat_top #(.STOP_BITS(2)) u_dut2 (
    .clk_16x(clk), .rst_n(rst_n), .din_rdy(din_rdy), .din_byte(din_byte),
    .ser_out(ser2), .tx_busy(busy2), .tx_done(done2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line level in cycle n of a frame (n=1 is the cycle after the accepting edge).
  function automatic logic exp_line(input logic [7:0] b, input int n, input int stops);
    int idx;
    int nb;
    idx = (n - 1) / 16;
    nb  = 10 + P + stops - 1;
    if (n < 1 || idx >= nb) return 1'b1;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (P == 1 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Records ser_out/busy/done on negedges 1..ncyc; optionally drives din_rdy/din_byte meanwhile.
  task automatic capture(input bit sel, input int ncyc, input bit hold, input logic [7:0] byte1,
                         input int set_at, input logic [7:0] set_byte, input int clear_at);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      ln[n] = sel ? ser2 : ser1;
      bz[n] = sel ? busy2 : busy1;
      dn[n] = sel ? done2 : done1;
      if (n == 1) begin
        din_rdy  = hold;
        din_byte = byte1;
      end
      if (n == set_at) begin
        din_rdy  = 1'b1;
        din_byte = set_byte;
      end
      if (n == clear_at) din_rdy = 1'b0;
    end
  endtask

  function automatic int frame_errs(input logic [7:0] b, input int off, input int stops,
                                    input int lo, input int hi);
    int e;
    e = 0;
    for (int n = lo; n <= hi; n++)
      if (ln[n] !== exp_line(b, n - off, stops)) e++;
    return e;
  endfunction

  function automatic logic [7:0] decode(input int off);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ln[off + 16 * (i + 1) + 8];
    return r;
  endfunction

  function automatic int count_hi(input bit which_done, input int lo, input int hi);
    int c;
    c = 0;
    for (int n = lo; n <= hi; n++)
      if (which_done ? (dn[n] === 1'b1) : (bz[n] === 1'b1)) c++;
    return c;
  endfunction

  function automatic int first_done(input int hi);
    for (int n = 1; n <= hi; n++)
      if (dn[n] === 1'b1) return n;
    return -1;
  endfunction

  task automatic start(input logic [7:0] b);
    din_rdy  = 1'b1;
    din_byte = b;
  endtask

  logic [7:0] lb_bytes [0:3];
  int done_seen;

  initial begin
    lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h5A; lb_bytes[3] = 8'hA5;

    // Reset state, with din_rdy asserted to confirm it is ignored under reset.
    din_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ser_out", ser1, 1);
    check_eq("rst_busy", busy1, 0);
    check_eq("rst_done", done1, 0);
    din_rdy = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_ser_out", ser1, 1);

    // Single byte 0x55; din_byte changed right after accept must not matter.
    start(8'h55);
    capture(0, FL1 + 8, 0, 8'hAA, 0, 8'h00, 0);
    check_eq("b55_start_bit", ln[1], 0);
    check_eq("b55_frame", frame_errs(8'h55, 0, 1, 1, FL1 + 8), 0);
    check_eq("b55_decode", decode(0), 8'h55);
    check_eq("b55_busy_cycles", count_hi(0, 1, FL1 + 8), FL1);
    check_eq("b55_done_cycle", first_done(FL1 + 8), FL1 + 1);
    check_eq("b55_done_count", count_hi(1, 1, FL1 + 8), 1);
    check_eq("b55_busy_in_done", bz[FL1 + 1], 0);

    // Busy ignore: 0xFF strobe at cycle 40 of an 0xA5 frame.
    start(8'hA5);
    capture(0, 2 * FL1 + 4, 0, 8'hA5, 40, 8'hFF, 41);
    check_eq("bsy_frame", frame_errs(8'hA5, 0, 1, 1, 2 * FL1 + 4), 0);
    check_eq("bsy_decode", decode(0), 8'hA5);
    check_eq("bsy_done_count", count_hi(1, 1, 2 * FL1 + 4), 1);
    check_eq("bsy_busy_cycles", count_hi(0, 1, 2 * FL1 + 4), FL1);

    // Back-to-back: din_rdy held, 0xC3 presented from cycle 1 through the tx_done cycle.
    start(8'h3C);
    capture(0, 2 * FL1 + 4, 1, 8'hC3, 0, 8'h00, FL1 + 2);
    check_eq("b2b_frame1", frame_errs(8'h3C, 0, 1, 1, FL1 + 1), 0);
    check_eq("b2b_done1", dn[FL1 + 1], 1);
    check_eq("b2b_start2", ln[FL1 + 2], 0);
    check_eq("b2b_busy2", bz[FL1 + 2], 1);
    check_eq("b2b_frame2", frame_errs(8'hC3, FL1 + 1, 1, FL1 + 2, 2 * FL1 + 4), 0);
    check_eq("b2b_decode2", decode(FL1 + 1), 8'hC3);
    check_eq("b2b_done_count", count_hi(1, 1, 2 * FL1 + 4), 2);
    check_eq("b2b_done2_cycle", dn[2 * FL1 + 2], 1);

`ifdef UAT_PARITY_EN
    start(8'h07);
    capture(0, FL1 + 4, 0, 8'h07, 0, 8'h00, 0);
    check_eq("par07_bit", ln[16 * 9 + 8], 1);
    check_eq("par07_len", first_done(FL1 + 4), 177);
    start(8'h03);
    capture(0, FL1 + 4, 0, 8'h03, 0, 8'h00, 0);
    check_eq("par03_bit", ln[16 * 9 + 8], 0);
    check_eq("par03_frame", frame_errs(8'h03, 0, 1, 1, FL1 + 4), 0);
`endif

    // Reset at cycle 70 of an 0x81 frame.
    start(8'h81);
    capture(0, 70, 0, 8'h81, 0, 8'h00, 0);
    check_eq("rmf_pre_frame", frame_errs(8'h81, 0, 1, 1, 70), 0);
    rst_n = 1'b0;
    #1;
    check_eq("rmf_ser_out", ser1, 1);
    check_eq("rmf_busy", busy1, 0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) done_seen++;
    end
    rst_n = 1'b1;
    start(8'h42);
    capture(0, FL1 + 4, 0, 8'h42, 0, 8'h00, 0);
    done_seen += (first_done(FL1 + 4) == FL1 + 1) ? 0 : 1;
    check_eq("rmf_no_done", done_seen, 0);
    check_eq("rmf_new_frame", frame_errs(8'h42, 0, 1, 1, FL1 + 4), 0);
    check_eq("rmf_new_decode", decode(0), 8'h42);

    // Loopback-style decode, 1 then 2 stop bits (reset between to realign both instances).
    for (int s = 1; s <= 2; s++) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        start(lb_bytes[k]);
        capture(s == 2, (s == 2 ? FL2 : FL1) + 4, 0, lb_bytes[k], 0, 8'h00, 0);
        check_eq($sformatf("lb_s%0d_decode_%0d", s, k), decode(0), lb_bytes[k]);
        check_eq($sformatf("lb_s%0d_frame_%0d", s, k),
                 frame_errs(lb_bytes[k], 0, s, 1, (s == 2 ? FL2 : FL1) + 4), 0);
        check_eq($sformatf("lb_s%0d_done_%0d", s, k),
                 first_done((s == 2 ? FL2 : FL1) + 4), (s == 2 ? FL2 : FL1) + 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
